// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, default moduli and field/repeat enums for the time-of-day chain
// Purpose: common definitions imported by mod_counter and time_of_day_counter.
// Contents:
//   MODE_RUN, MODE_SET_SEC/MIN/HOUR  3-bit mode encodings
//   DEF_SEC_MOD/DEF_MIN_MOD/DEF_HOUR_MOD  default moduli
//   field_e      field selected by the current mode
//   rpt_state_e  press-and-hold auto-repeat states
//   field_of()   mode -> field_e decode
package clock_pkg;

  localparam logic [2:0] MODE_RUN      = 3'b000;
  localparam logic [2:0] MODE_SET_SEC  = 3'b101;
  localparam logic [2:0] MODE_SET_MIN  = 3'b110;
  localparam logic [2:0] MODE_SET_HOUR = 3'b111;

  localparam int DEF_SEC_MOD  = 60;
  localparam int DEF_MIN_MOD  = 60;
  localparam int DEF_HOUR_MOD = 24;

  typedef enum logic [1:0] {
    FIELD_NONE,
    FIELD_SEC,
    FIELD_MIN,
    FIELD_HOUR
  } field_e;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  // Any mode outside the three set encodings means "run".
  function automatic field_e field_of(input logic [2:0] mode);
    case (mode)
      MODE_SET_SEC:  field_of = FIELD_SEC;
      MODE_SET_MIN:  field_of = FIELD_MIN;
      MODE_SET_HOUR: field_of = FIELD_HOUR;
      default:       field_of = FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_of_day_counter_mod_counter.sv
// rtl/time_of_day_counter_mod_counter.sv - modulo-MOD up/down counter with wrap carry
// Purpose: one field of the time-of-day chain (sec, min or hour).
// Ports:
//   clk_1Hz  in   clock
//   rst_n    in   asynchronous active-low reset, clears value
//   inc      in   step up, wraps MOD-1 -> 0
//   dec      in   step down, wraps 0 -> MOD-1
//   clr      in   synchronous clear (priority over inc/dec)
//   value    out  current count
//   carry    out  inc while at the top of the range (combinational)
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk_1Hz,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  // Values above MAX (possible when MOD does not fill W bits) behave as MAX.
  logic at_max;
  assign at_max = (value >= MAX);
  assign carry  = inc & at_max;

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + W'(1);
    end else if (dec) begin
      if (value == '0)
        value <= MAX;
      else if (at_max)
        value <= MAX - W'(1);
      else
        value <= value - W'(1);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - sec/min/hour chain with button set, auto-repeat and optional alarm
// Purpose: counts one second per clk_1Hz with ripple carry, pulses day_tick on wrap to 00:00:00,
//   lets the selected field be stepped with press-and-hold auto-repeat, and optionally rings an alarm.
// Configuration macro: ALARM_EN (undefined: alarm_ring tied 0, alarm inputs ignored).
// Ports:
//   clk_1Hz      in   1 Hz clock
//   rst_n        in   asynchronous active-low reset
//   mode         in   101 set sec, 110 set min, 111 set hour, others run
//   btn_up       in   active-low increment request
//   btn_down     in   active-low decrement request
//   alarm_hour   in   alarm hour
//   alarm_min    in   alarm minute
//   alarm_arm    in   alarm enabled
//   alarm_ack_n  in   active-low alarm silence
//   sec/min/hour out  current time
//   day_tick     out  one-cycle pulse in the cycle showing 00:00:00 after a wrap
//   alarm_ring   out  alarm active
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int SEC_MOD    = DEF_SEC_MOD,
  parameter int MIN_MOD    = DEF_MIN_MOD,
  parameter int HOUR_MOD   = DEF_HOUR_MOD,
  parameter int REPEAT_DLY = 2,
  parameter int ALARM_DUR  = 60
) (
  input  logic                        clk_1Hz,
  input  logic                        rst_n,
  input  logic [2:0]                  mode,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic [$clog2(HOUR_MOD)-1:0] alarm_hour,
  input  logic [$clog2(MIN_MOD)-1:0]  alarm_min,
  input  logic                        alarm_arm,
  input  logic                        alarm_ack_n,
  output logic [$clog2(SEC_MOD)-1:0]  sec,
  output logic [$clog2(MIN_MOD)-1:0]  min,
  output logic [$clog2(HOUR_MOD)-1:0] hour,
  output logic                        day_tick,
  output logic                        alarm_ring
);

  localparam int SW = $clog2(SEC_MOD);
  localparam int MW = $clog2(MIN_MOD);
  localparam int HW = $clog2(HOUR_MOD);
  localparam int CW = $clog2(REPEAT_DLY + 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_DLY - 1);

  field_e     fld;
  logic       run;
  logic       up_q, dn_q;
  logic [2:0] mode_q;
  rpt_state_e rpt_state;
  logic [CW-1:0] rpt_cnt;
  logic       press_up, press_dn, press, step;

  assign fld = field_of(mode);
  assign run = (fld == FIELD_NONE);

  // A press is exactly one registered button low, in a set mode that was
  // already selected last cycle; a mode change therefore restarts the hold.
  assign press_up = !up_q &&  dn_q;
  assign press_dn =  up_q && !dn_q;
  assign press    = !run && (press_up || press_dn) && (mode == mode_q);
  assign step     = press && (rpt_state != RPT_DELAY);

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      up_q      <= 1'b1;
      dn_q      <= 1'b1;
      mode_q    <= MODE_RUN;
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      up_q   <= btn_up;
      dn_q   <= btn_down;
      mode_q <= mode;
      if (!press) begin
        rpt_state <= RPT_IDLE;
        rpt_cnt   <= '0;
      end else begin
        case (rpt_state)
          RPT_IDLE: begin
            rpt_state <= RPT_DELAY;
            rpt_cnt   <= '0;
          end
          RPT_DELAY: begin
            if (rpt_cnt == RPT_LAST)
              rpt_state <= RPT_REPEAT;
            else
              rpt_cnt <= rpt_cnt + CW'(1);
          end
          default: rpt_state <= RPT_REPEAT;
        endcase
      end
    end
  end

  logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic sec_carry, min_carry, hour_carry;

  // Carries ripple only in run mode; set modes step one field in isolation.
  assign sec_inc  = run | ((fld == FIELD_SEC) & step & press_up);
  assign sec_dec  = (fld == FIELD_SEC) & step & press_dn;
  assign min_inc  = (run & sec_carry) | ((fld == FIELD_MIN) & step & press_up);
  assign min_dec  = (fld == FIELD_MIN) & step & press_dn;
  assign hour_inc = (run & min_carry) | ((fld == FIELD_HOUR) & step & press_up);
  assign hour_dec = (fld == FIELD_HOUR) & step & press_dn;

  mod_counter #(.MOD(SEC_MOD), .W(SW)) u_sec (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .inc(sec_inc), .dec(sec_dec), .clr(1'b0),
    .value(sec), .carry(sec_carry)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MW)) u_min (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .inc(min_inc), .dec(min_dec), .clr(1'b0),
    .value(min), .carry(min_carry)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(HW)) u_hour (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .inc(hour_inc), .dec(hour_dec), .clr(1'b0),
    .value(hour), .carry(hour_carry)
  );

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n)
      day_tick <= 1'b0;
    else
      day_tick <= run & hour_carry;
  end

`ifdef ALARM_EN
  localparam int RW = $clog2(ALARM_DUR + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_DUR - 1);

  logic [RW-1:0] ring_cnt;
  logic          alarm_hit;

  assign alarm_hit = run && alarm_arm && (hour == alarm_hour) &&
                     (min == alarm_min) && (sec == '0);

  // While ringing, a new match is ignored; the ring ends on ack, disarm or timeout.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (alarm_ring) begin
      if (!alarm_ack_n || !alarm_arm || (ring_cnt == RING_LAST)) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else begin
        ring_cnt <= ring_cnt + RW'(1);
      end
    end else if (alarm_hit) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= '0;
    end
  end
`else
  localparam int unused_alarm_dur = ALARM_DUR;
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour, alarm_min, alarm_arm, alarm_ack_n};
  assign alarm_ring   = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - self-checking bench for time_of_day_counter with a behavioural clock model
module tb_time_of_day_counter;

  localparam int SEC_MOD    = 60;
  localparam int MIN_MOD    = 60;
  localparam int HOUR_MOD   = 24;
  localparam int REPEAT_DLY = 2;
  localparam int ALARM_DUR  = 60;
  localparam int DAY        = SEC_MOD * MIN_MOD * HOUR_MOD;

  logic       clk_1Hz = 1'b0;
  logic       rst_n;
  logic [2:0] mode;
  logic       btn_up, btn_down;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_arm, alarm_ack_n;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       day_tick, alarm_ring;

  int errors = 0;
  int checks = 0;

  // Reference model state: time as separate fields, hold length in cycles.
  int   m_h, m_m, m_s, held, ring_len;
  bit   m_tick, m_ring, m_up_q, m_dn_q;
  logic [2:0] m_mode_q;

  time_of_day_counter #(
    .SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD), .HOUR_MOD(HOUR_MOD),
    .REPEAT_DLY(REPEAT_DLY), .ALARM_DUR(ALARM_DUR)
  ) dut (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .mode(mode),
    .btn_up(btn_up), .btn_down(btn_down),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_arm(alarm_arm), .alarm_ack_n(alarm_ack_n),
    .sec(sec), .min(min), .hour(hour),
    .day_tick(day_tick), .alarm_ring(alarm_ring)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; held = 0; ring_len = 0;
    m_tick = 0; m_ring = 0; m_up_q = 1; m_dn_q = 1; m_mode_q = 3'b000;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    int f, total, d;
    bit pu, pd;
    f = (mode == 3'b101) ? 1 : (mode == 3'b110) ? 2 : (mode == 3'b111) ? 3 : 0;
`ifdef ALARM_EN
    if (m_ring) begin
      if (!alarm_ack_n || !alarm_arm || ring_len >= ALARM_DUR) m_ring = 0;
      else ring_len++;
    end else if (f == 0 && alarm_arm && m_h == int'(alarm_hour) &&
                 m_m == int'(alarm_min) && m_s == 0) begin
      m_ring = 1;
      ring_len = 1;
    end
`endif
    pu = !m_up_q && m_dn_q;
    pd = m_up_q && !m_dn_q;
    m_tick = 0;
    if (f == 0) begin
      held = 0;
      total = ((m_h * MIN_MOD + m_m) * SEC_MOD + m_s + 1) % DAY;
      m_tick = (total == 0);
      m_h = total / (MIN_MOD * SEC_MOD);
      m_m = (total / SEC_MOD) % MIN_MOD;
      m_s = total % SEC_MOD;
    end else if ((pu || pd) && mode == m_mode_q) begin
      held++;
      if (held == 1 || held > REPEAT_DLY + 1) begin
        d = pu ? 1 : -1;
        case (f)
          1: m_s = (m_s + d + SEC_MOD) % SEC_MOD;
          2: m_m = (m_m + d + MIN_MOD) % MIN_MOD;
          default: m_h = (m_h + d + HOUR_MOD) % HOUR_MOD;
        endcase
      end
    end else begin
      held = 0;
    end
    m_up_q = btn_up;
    m_dn_q = btn_down;
    m_mode_q = mode;
  endtask

  // Called at a negedge with inputs stable; returns at the next negedge.
  task automatic cycle();
    model_edge();
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
  endtask

  // Stepping utility: pulse btn_up until the model field reaches target.
  task automatic set_field(input logic [2:0] md, input int target);
    int cur, modv, n;
    mode = md; btn_up = 1; btn_down = 1;
    cycle();
    cur  = (md == 3'b101) ? m_s : (md == 3'b110) ? m_m : m_h;
    modv = (md == 3'b101) ? SEC_MOD : (md == 3'b110) ? MIN_MOD : HOUR_MOD;
    n = (target - cur + modv) % modv;
    for (int i = 0; i < n; i++) begin
      btn_up = 0; cycle();
      btn_up = 1; cycle();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if ({hour, min, sec, day_tick, alarm_ring} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d:%0d:%0d tick=%b ring=%b, want all 0",
               hour, min, sec, day_tick, alarm_ring);
    end
    @(negedge clk_1Hz);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_run();
    bit tick_seen = 0;
    mode = 3'b000;
    for (int i = 0; i < 3661; i++) begin
      cycle();
      tick_seen |= day_tick;
    end
    checks++;
    if (hour !== 5'd1) begin errors++; $display("FAIL run_hour: got %0d want 1", hour); end
    checks++;
    if (min !== 6'd1) begin errors++; $display("FAIL run_min: got %0d want 1", min); end
    checks++;
    if (sec !== 6'd1) begin errors++; $display("FAIL run_sec: got %0d want 1", sec); end
    checks++;
    if (tick_seen !== 1'b0) begin errors++; $display("FAIL run_no_tick: day_tick seen=%b want 0", tick_seen); end
  endtask

  task automatic test_day_wrap();
    set_field(3'b111, 23);
    set_field(3'b110, 59);
    set_field(3'b101, 58);
    mode = 3'b000;
    cycle();
    checks++;
    if ({hour, min, sec, day_tick} !== {5'd23, 6'd59, 6'd59, 1'b0}) begin
      errors++;
      $display("FAIL wrap_pre: got %0d:%0d:%0d tick=%b want 23:59:59 tick=0", hour, min, sec, day_tick);
    end
    cycle();
    checks++;
    if ({hour, min, sec, day_tick} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_zero: got %0d:%0d:%0d tick=%b want 0:0:0 tick=1", hour, min, sec, day_tick);
    end
    cycle();
    checks++;
    if ({hour, min, sec, day_tick} !== {5'd0, 6'd0, 6'd1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_post: got %0d:%0d:%0d tick=%b want 0:0:1 tick=0", hour, min, sec, day_tick);
    end
  endtask

  task automatic test_set_hour();
    logic [5:0] m0, s0;
    set_field(3'b111, 23);
    m0 = min; s0 = sec;
    checks++;
    if (hour !== 5'd23) begin errors++; $display("FAIL set_hour_pre: got %0d want 23", hour); end
    btn_up = 0; cycle();
    btn_up = 1; cycle();
    cycle();
    checks++;
    if (hour !== 5'd0) begin errors++; $display("FAIL set_hour_wrap: got %0d want 0", hour); end
    checks++;
    if ({min, sec} !== {m0, s0} || {min, sec} !== {6'(m_m), 6'(m_s)}) begin
      errors++;
      $display("FAIL set_hour_freeze: got min=%0d sec=%0d want %0d %0d", min, sec, m_m, m_s);
    end
  endtask

  task automatic test_hold_repeat();
    int exp_min [6] = '{59, 59, 59, 58, 57, 56};
    set_field(3'b110, 0);
    btn_down = 0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (min !== 6'(exp_min[i])) begin
        errors++;
        $display("FAIL hold_repeat[%0d]: got min=%0d want %0d", i, min, exp_min[i]);
      end
    end
    // btn_up joins at the register one cycle late, so one more step lands first.
    btn_up = 0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (min !== 6'd55) begin
        errors++;
        $display("FAIL both_low[%0d]: got min=%0d want 55", i, min);
      end
    end
    btn_up = 1; btn_down = 1;
    cycle();
  endtask

  task automatic test_async_reset();
    int exp_min [4] = '{0, 1, 1, 1};
    set_field(3'b111, 12);
    set_field(3'b110, 34);
    set_field(3'b101, 56);
    mode = 3'b110; btn_up = 0;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if ({hour, min, sec} !== {5'd12, 6'd35, 6'd56}) begin
      errors++;
      $display("FAIL pre_reset: got %0d:%0d:%0d want 12:35:56", hour, min, sec);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({hour, min, sec, day_tick, alarm_ring} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got %0d:%0d:%0d tick=%b ring=%b want all 0",
               hour, min, sec, day_tick, alarm_ring);
    end
    model_reset();
    @(negedge clk_1Hz);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (min !== 6'(exp_min[i])) begin
        errors++;
        $display("FAIL post_reset_press[%0d]: got min=%0d want %0d", i, min, exp_min[i]);
      end
    end
    btn_up = 1;
    cycle();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 7);
        mode = (r < 3) ? 3'($urandom_range(0, 4)) : (r == 3) ? 3'b101 : (r < 6) ? 3'b110 : 3'b111;
      end
      if ($urandom_range(0, 3) == 0) btn_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) btn_down = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if ({hour, min, sec, day_tick, alarm_ring} !==
          {5'(m_h), 6'(m_m), 6'(m_s), m_tick, m_ring}) begin
        errors++;
        $display("FAIL random[%0d]: got %0d:%0d:%0d tick=%b ring=%b want %0d:%0d:%0d tick=%b ring=%b",
                 i, hour, min, sec, day_tick, alarm_ring, m_h, m_m, m_s, m_tick, m_ring);
      end
    end
    mode = 3'b000; btn_up = 1; btn_down = 1;
    cycle();
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    int n;
    set_field(3'b111, 6);
    set_field(3'b110, 59);
    set_field(3'b101, 59);
    alarm_hour = 5'd7; alarm_min = 6'd0; alarm_arm = 1; alarm_ack_n = 1;
    mode = 3'b000;
    cycle();
    checks++;
    if ({hour, min, sec, alarm_ring} !== {5'd7, 6'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL alarm_match: got %0d:%0d:%0d ring=%b want 7:0:0 ring=0", hour, min, sec, alarm_ring);
    end
    cycle();
    checks++;
    if (alarm_ring !== 1'b1 || m_ring !== 1'b1) begin
      errors++;
      $display("FAIL alarm_start: got ring=%b want 1", alarm_ring);
    end
    n = 1;
    while (alarm_ring === 1'b1 && n < 4 * ALARM_DUR) begin
      cycle();
      if (alarm_ring === 1'b1) n++;
    end
    checks++;
    if (n != ALARM_DUR || m_ring !== 1'b0) begin
      errors++;
      $display("FAIL alarm_duration: got %0d cycles want %0d", n, ALARM_DUR);
    end
    alarm_hour = 5'(m_h);
    alarm_min  = 6'((m_m + 1) % MIN_MOD);
    n = 0;
    while (alarm_ring !== 1'b1 && n < 2 * SEC_MOD + 5) begin
      cycle();
      n++;
    end
    checks++;
    if (alarm_ring !== 1'b1) begin
      errors++;
      $display("FAIL alarm_second_ring: got ring=%b after %0d cycles want 1", alarm_ring, n);
    end
    alarm_ack_n = 0;
    cycle();
    checks++;
    if (alarm_ring !== 1'b0 || m_ring !== 1'b0) begin
      errors++;
      $display("FAIL alarm_ack: got ring=%b want 0", alarm_ring);
    end
    alarm_ack_n = 1; alarm_arm = 0;
    cycle();
  endtask
`endif

  initial begin
    rst_n = 0; mode = 3'b000; btn_up = 1; btn_down = 1;
    alarm_hour = '0; alarm_min = '0; alarm_arm = 0; alarm_ack_n = 1;
    model_reset();
    test_reset();
    test_run();
    test_day_wrap();
    test_set_hour();
    test_hold_repeat();
    test_async_reset();
    test_random();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
